calc_entry_sequencer: RTL and testbench

- Control FSM for the calculator entry path: turns raw keypad events (valid + digit) into load strobes for the operand/number memory.
- Runs the ALU start/done handshake with a timeout.
- Drives result/error display flags.
- Sits between the keypad decoder and the memory/ALU datapath, all on the Clock_1ms domain.

---
 rtl/calc_entry_sequencer_pkg.sv | 40 ++++
 rtl/calc_entry_sequencer_if.sv | 32 +++
 rtl/calc_entry_sequencer_key_event_detect.sv | 19 +
 rtl/calc_entry_sequencer.sv | 145 ++++++++++++++
 tb/tb_calc_entry_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_entry_sequencer_pkg.sv
// Shared constants for the calculator entry path: state codes, key codes
// and the key classifier used by the entry sequencer.
package calc_pkg;

  localparam int DEFAULT_MAX_DIGITS   = 3;
  localparam int DEFAULT_CALC_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_NUM1   = 3'b001,
    ST_OP     = 3'b010,
    ST_NUM2   = 3'b100,
    ST_CALC   = 3'b011,
    ST_RESULT = 3'b101,
    ST_ERROR  = 3'b111
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [1:0] {
    KC_DIGIT,
    KC_OP,
    KC_EQ,
    KC_CLR
  } key_class_t;

  function automatic key_class_t classify(input logic [3:0] key);
    key_class_t kc;
    kc = KC_DIGIT;
    if (key inside {KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV}) kc = KC_OP;
    else if (key == KEY_EQ) kc = KC_EQ;
    else if (key == KEY_CLR) kc = KC_CLR;
    return kc;
  endfunction

endpackage

// File: rtl/calc_entry_sequencer_if.sv
// Keypad/ALU inputs and memory/display outputs of the entry sequencer.
// The master side is the surrounding datapath, the slave side the sequencer.
interface calc_entry_sequencer_if;

  logic       valid;
  logic [3:0] digit;
  logic       alu_done;
  logic       alu_error;
  logic [2:0] memoryState;
  logic [1:0] validCount;
  logic       digitLoad;
  logic       numberSelect;
  logic       numberClear;
  logic       opLoad;
  logic [3:0] operandCode;
  logic       alu_start;
  logic       resultShow;
  logic       error;

  modport master (
    output valid, digit, alu_done, alu_error,
    input  memoryState, validCount, digitLoad, numberSelect, numberClear,
           opLoad, operandCode, alu_start, resultShow, error
  );

  modport slave (
    input  valid, digit, alu_done, alu_error,
    output memoryState, validCount, digitLoad, numberSelect, numberClear,
           opLoad, operandCode, alu_start, resultShow, error
  );

endinterface

// File: rtl/calc_entry_sequencer_key_event_detect.sv
// Rising-edge detector on the keypad level. The history register resets to 1
// so a key held through reset only counts after it is released and pressed again.
module key_event_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic keyEvt_o
);

  logic valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) valid_q <= 1'b1;
    else       valid_q <= valid_i;
  end

  assign keyEvt_o = valid_i & ~valid_q;

endmodule

// File: rtl/calc_entry_sequencer.sv
// Entry sequencer: turns keypad events into number/operand load strobes,
// runs the ALU start/done handshake with a timeout and drives display flags.
module calc_entry_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS   = DEFAULT_MAX_DIGITS,
  parameter int CALC_TIMEOUT = DEFAULT_CALC_TIMEOUT
) (
  input logic                   Clock_1ms,
  input logic                   Reset,
  calc_entry_sequencer_if.slave bus
);

  localparam logic [1:0] MAX_CNT      = 2'(MAX_DIGITS);
  localparam logic [7:0] TIMEOUT_LAST = 8'(CALC_TIMEOUT - 1);

  state_t     state_q;
  logic [1:0] validCount_q;
  logic       digitLoad_q;
  logic       numberSelect_q;
  logic       numberClear_q;
  logic       opLoad_q;
  logic [3:0] operandCode_q;
  logic       aluStart_q;
  logic       resultShow_q;
  logic       error_q;
  logic [7:0] timer_q;
  logic       keyEvt;
  key_class_t keyClass;

  key_event_detect u_keyEvent (
    .clk_i    (Clock_1ms),
    .rst_i    (Reset),
    .valid_i  (bus.valid),
    .keyEvt_o (keyEvt)
  );

  assign keyClass = classify(bus.digit);

  always_ff @(posedge Clock_1ms or posedge Reset) begin
    if (Reset) begin
      state_q        <= ST_NUM1;
      validCount_q   <= '0;
      digitLoad_q    <= 1'b0;
      numberSelect_q <= 1'b0;
      numberClear_q  <= 1'b0;
      opLoad_q       <= 1'b0;
      operandCode_q  <= '0;
      aluStart_q     <= 1'b0;
      resultShow_q   <= 1'b0;
      error_q        <= 1'b0;
      timer_q        <= '0;
    end else begin
      digitLoad_q   <= 1'b0;
      numberClear_q <= 1'b0;
      opLoad_q      <= 1'b0;
      aluStart_q    <= 1'b0;
      timer_q       <= '0;
      // Clear beats everything, including an ALU result arriving on the same edge.
      if (keyEvt && keyClass == KC_CLR) begin
        state_q        <= ST_NUM1;
        numberClear_q  <= 1'b1;
        validCount_q   <= '0;
        operandCode_q  <= '0;
        numberSelect_q <= 1'b0;
        resultShow_q   <= 1'b0;
        error_q        <= 1'b0;
      end else begin
        case (state_q)
          ST_NUM1, ST_NUM2: begin
            if (keyEvt && keyClass == KC_DIGIT) begin
              if (validCount_q < MAX_CNT) begin
                digitLoad_q    <= 1'b1;
                numberSelect_q <= (state_q == ST_NUM2);
                validCount_q   <= validCount_q + 2'd1;
              end
            end else if (keyEvt && keyClass == KC_OP && state_q == ST_NUM1) begin
              opLoad_q      <= 1'b1;
              operandCode_q <= bus.digit;
              validCount_q  <= '0;
              state_q       <= ST_OP;
            end else if (keyEvt && keyClass == KC_EQ && state_q == ST_NUM2 &&
                         validCount_q != 2'd0) begin
              aluStart_q <= 1'b1;
              state_q    <= ST_CALC;
            end
          end
          ST_OP: begin
            if (keyEvt && keyClass == KC_OP) begin
              opLoad_q      <= 1'b1;
              operandCode_q <= bus.digit;
            end else if (keyEvt && keyClass == KC_DIGIT) begin
              digitLoad_q    <= 1'b1;
              numberSelect_q <= 1'b1;
              validCount_q   <= 2'd1;
              state_q        <= ST_NUM2;
            end
          end
          ST_CALC: begin
            if (bus.alu_done) begin
              if (bus.alu_error) begin
                state_q <= ST_ERROR;
                error_q <= 1'b1;
              end else begin
                state_q      <= ST_RESULT;
                resultShow_q <= 1'b1;
              end
            end else if (timer_q == TIMEOUT_LAST) begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end else begin
              timer_q <= timer_q + 8'd1;
            end
          end
          ST_RESULT: begin
            // A new digit starts a fresh number1; memory applies the clear before the load.
            if (keyEvt && keyClass == KC_DIGIT) begin
              numberClear_q  <= 1'b1;
              digitLoad_q    <= 1'b1;
              numberSelect_q <= 1'b0;
              validCount_q   <= 2'd1;
              resultShow_q   <= 1'b0;
              state_q        <= ST_NUM1;
            end
          end
          ST_ERROR: begin
          end
          default: state_q <= ST_NUM1;
        endcase
      end
    end
  end

  assign bus.memoryState  = state_q;
  assign bus.validCount   = validCount_q;
  assign bus.digitLoad    = digitLoad_q;
  assign bus.numberSelect = numberSelect_q;
  assign bus.numberClear  = numberClear_q;
  assign bus.opLoad       = opLoad_q;
  assign bus.operandCode  = operandCode_q;
  assign bus.alu_start    = aluStart_q;
  assign bus.resultShow   = resultShow_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Scoreboard bench for calc_entry_sequencer: a behavioural keypad/calculator
// model queues the expected outputs per clock, a negedge monitor compares them.
module tb_calc_entry_sequencer;

  localparam int TIMEOUT = 255;
  localparam logic [2:0] M_NUM1 = 3'b001, M_OP = 3'b010, M_NUM2 = 3'b100;
  localparam logic [2:0] M_CALC = 3'b011, M_RES = 3'b101, M_ERR = 3'b111;

  typedef struct packed {
    logic [2:0] state;
    logic [1:0] count;
    logic       dl;
    logic       sel;
    logic       clr;
    logic       opl;
    logic [3:0] op;
    logic       start;
    logic       rs;
    logic       err;
  } obs_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  obs_t expQ[$];
  obs_t mod;
  obs_t resetObs;
  logic mPrev;
  int   mCalcCycles;

  calc_entry_sequencer_if bus ();

  calc_entry_sequencer #(.MAX_DIGITS(3), .CALC_TIMEOUT(TIMEOUT)) dut (
    .Clock_1ms (clk),
    .Reset     (rst),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t sampleDut();
    obs_t s;
    s.state = bus.memoryState;
    s.count = bus.validCount;
    s.dl    = bus.digitLoad;
    s.sel   = bus.numberSelect;
    s.clr   = bus.numberClear;
    s.opl   = bus.opLoad;
    s.op    = bus.operandCode;
    s.start = bus.alu_start;
    s.rs    = bus.resultShow;
    s.err   = bus.error;
    return s;
  endfunction

  task automatic checkOutput(input string name, input obs_t exp);
    obs_t got;
    got = sampleDut();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got st=%b cnt=%0d dl=%b sel=%b clr=%b opl=%b op=%h start=%b rs=%b err=%b, expected st=%b cnt=%0d dl=%b sel=%b clr=%b opl=%b op=%h start=%b rs=%b err=%b",
               name, $time, got.state, got.count, got.dl, got.sel, got.clr, got.opl, got.op,
               got.start, got.rs, got.err, exp.state, exp.count, exp.dl, exp.sel, exp.clr,
               exp.opl, exp.op, exp.start, exp.rs, exp.err);
    end
  endtask

  task automatic modelReset();
    mod         = resetObs;
    mPrev       = 1'b1;
    mCalcCycles = 0;
  endtask

  // Calculator behaviour expressed as key presses acting on a small set of
  // model variables; pulses live for the one clock that follows the press.
  task automatic modelStep(input logic v, input logic [3:0] d, input logic done, input logic aerr);
    bit press, isDigit, isOp, isEq;
    press   = v && !mPrev;
    mPrev   = v;
    isDigit = (d <= 4'd9);
    isOp    = (d >= 4'hA) && (d <= 4'hD);
    isEq    = (d == 4'hE);
    mod.dl = 0; mod.clr = 0; mod.opl = 0; mod.start = 0;
    if (press && d == 4'hF) begin
      mod.clr = 1; mod.count = 0; mod.op = 0; mod.sel = 0;
      mod.rs = 0; mod.err = 0; mod.state = M_NUM1;
    end else if (mod.state == M_CALC) begin
      if (done) begin
        if (aerr) begin mod.state = M_ERR; mod.err = 1; end
        else begin mod.state = M_RES; mod.rs = 1; end
      end else begin
        mCalcCycles++;
        if (mCalcCycles == TIMEOUT) begin mod.state = M_ERR; mod.err = 1; end
      end
    end else if (press) begin
      if (mod.state == M_NUM1 || mod.state == M_NUM2) begin
        if (isDigit && mod.count < 3) begin
          mod.dl = 1; mod.sel = (mod.state == M_NUM2); mod.count++;
        end else if (isOp && mod.state == M_NUM1) begin
          mod.opl = 1; mod.op = d; mod.count = 0; mod.state = M_OP;
        end else if (isEq && mod.state == M_NUM2 && mod.count > 0) begin
          mod.start = 1; mCalcCycles = 0; mod.state = M_CALC;
        end
      end else if (mod.state == M_OP) begin
        if (isOp) begin mod.opl = 1; mod.op = d; end
        else if (isDigit) begin
          mod.dl = 1; mod.sel = 1; mod.count = 1; mod.state = M_NUM2;
        end
      end else if (mod.state == M_RES && isDigit) begin
        mod.clr = 1; mod.dl = 1; mod.sel = 0; mod.count = 1; mod.rs = 0; mod.state = M_NUM1;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic done, input logic aerr);
    bus.valid     = v;
    bus.digit     = d;
    bus.alu_done  = done;
    bus.alu_error = aerr;
    modelStep(v, d, done, aerr);
    expQ.push_back(mod);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic pressKey(input logic [3:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0);
    applyStimulus(1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic enterCalc();
    pressKey(4'd1);
    pressKey(4'hA);
    pressKey(4'd2);
    pressKey(4'hE);
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (!rst && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("cycle", e);
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    resetObs = '{state: M_NUM1, count: 2'd0, dl: 1'b0, sel: 1'b0, clr: 1'b0, opl: 1'b0,
                 op: 4'd0, start: 1'b0, rs: 1'b0, err: 1'b0};
    rst           = 1'b1;
    bus.valid     = 1'b1;
    bus.digit     = 4'd0;
    bus.alu_done  = 1'b0;
    bus.alu_error = 1'b0;
    #3;
    checkOutput("reset_values", resetObs);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    modelReset();

    $display("[TB] key held through reset, then digits 1..4");
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) pressKey(4'(k));

    $display("[TB] operator replace and normal result");
    pressKey(4'hF);
    pressKey(4'd5);
    pressKey(4'hA);
    pressKey(4'hB);
    pressKey(4'd7);
    pressKey(4'hE);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);

    $display("[TB] ALU error path");
    pressKey(4'hF);
    pressKey(4'd9);
    pressKey(4'hD);
    pressKey(4'd0);
    pressKey(4'hE);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
    pressKey(4'd4);
    pressKey(4'hF);

    $display("[TB] CALC timeout");
    enterCalc();
    for (int c = 0; c < TIMEOUT + 5; c++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    pressKey(4'hF);

    $display("[TB] digit from RESULT");
    enterCalc();
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    pressKey(4'hE);
    pressKey(4'hA);
    pressKey(4'd6);

    $display("[TB] clear on the same edge as alu_done");
    pressKey(4'hF);
    enterCalc();
    applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'hF, 1'b0, 1'b0);

    $display("[TB] asynchronous reset inside CALC");
    enterCalc();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    bus.valid = 1'b1;
    bus.digit = 4'd5;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", resetObs);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd5, 1'b0, 1'b0);
    pressKey(4'd5);

    $display("[TB] randomized keys and ALU responses");
    for (int r = 0; r < 800; r++) begin
      logic       v;
      logic [3:0] d;
      logic       done;
      logic       aerr;
      v    = ($urandom_range(0, 2) != 0);
      d    = 4'($urandom_range(0, 15));
      if (d == 4'hF && $urandom_range(0, 3) != 0) d = 4'hE;
      done = ($urandom_range(0, 7) == 0);
      aerr = ($urandom_range(0, 3) == 0);
      applyStimulus(v, d, done, aerr);
    end

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
